// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_operand_stage_if                                        |
// | Description : Decode-to-execute operand bus. The decode side (master)     |
// |               drives instruction fields, register-file reads, bypass      |
// |               channels and pipeline control; the operand stage (slave)    |
// |               returns registered operands, status and the hazard flag.    |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface alu_operand_stage_if #(
   parameter int DATA_W  = 16,
   parameter int IMM_S_W = 8,
   parameter int IMM_L_W = 11,
   parameter int REG_AW  = 3,
   parameter int NUM_FWD = 2
);
   logic                        in_valid;
   logic [1:0]                  a_sel;
   logic [2:0]                  b_sel;
   logic [REG_AW-1:0]           rs_a;
   logic [REG_AW-1:0]           rs_b;
   logic [DATA_W-1:0]           rf_a;
   logic [DATA_W-1:0]           rf_b;
   logic [IMM_S_W-1:0]          imm_s;
   logic [IMM_L_W-1:0]          imm_l;
   logic [DATA_W-1:0]           pc;
   logic [NUM_FWD-1:0]          fwd_valid;
   logic [NUM_FWD-1:0]          fwd_pend;
   logic [NUM_FWD*REG_AW-1:0]   fwd_idx;
   logic [NUM_FWD*DATA_W-1:0]   fwd_data;
   logic                        stall;
   logic                        flush;
   logic [DATA_W-1:0]           op_a;
   logic [DATA_W-1:0]           op_b;
   logic                        out_valid;
   logic                        hazard;
   logic                        fwd_hit_a;
   logic                        fwd_hit_b;

   modport master (
      output in_valid, a_sel, b_sel, rs_a, rs_b, rf_a, rf_b, imm_s, imm_l, pc,
             fwd_valid, fwd_pend, fwd_idx, fwd_data, stall, flush,
      input  op_a, op_b, out_valid, hazard, fwd_hit_a, fwd_hit_b
   );

   modport slave (
      input  in_valid, a_sel, b_sel, rs_a, rs_b, rf_a, rf_b, imm_s, imm_l, pc,
             fwd_valid, fwd_pend, fwd_idx, fwd_data, stall, flush,
      output op_a, op_b, out_valid, hazard, fwd_hit_a, fwd_hit_b
   );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_operand_stage                                           |
// | Description : Registered ALU operand-select stage. Builds operands A/B    |
// |               from register reads, immediates and PC, bypasses results    |
// |               from later stages, flags load-use hazards and honours       |
// |               stall/flush. Operands appear one cycle after issue.         |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module alu_operand_stage #(
   parameter int DATA_W  = 16,
   parameter int IMM_S_W = 8,
   parameter int IMM_L_W = 11,
   parameter int REG_AW  = 3,
   parameter int NUM_FWD = 2
) (
   input  logic               clk,
   input  logic               reset,
   alu_operand_stage_if.slave bus
);

   localparam int c_HALF_W = DATA_W / 2;

   logic [NUM_FWD-1:0] w_match_a;
   logic [NUM_FWD-1:0] w_match_b;
   logic [DATA_W-1:0]  w_ra;
   logic [DATA_W-1:0]  w_rb;
   logic               w_hit_a;
   logic               w_hit_b;
   logic               w_pend_a;
   logic               w_pend_b;
   logic               w_use_a;
   logic               w_use_b;
   logic               w_fwd_hit_a;
   logic               w_fwd_hit_b;
   logic               w_hazard;
   logic               w_load;
   logic [DATA_W-1:0]  w_op_a;
   logic [DATA_W-1:0]  w_op_b;
   logic [DATA_W-1:0]  w_imm_s_sext;
   logic [DATA_W-1:0]  w_imm_s_zext;
   logic [DATA_W-1:0]  w_imm_s_hi;
   logic [DATA_W-1:0]  w_imm_l_shl;
   logic [DATA_W-1:0]  w_ra_lo_zext;

   logic [DATA_W-1:0]  r_op_a;
   logic [DATA_W-1:0]  r_op_b;
   logic               r_valid;
   logic               r_fwd_hit_a;
   logic               r_fwd_hit_b;

   // Per-channel destination match against both source registers; register 0
   // gets no special treatment.
   generate
      for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
         assign w_match_a[gi] = bus.fwd_valid[gi] &&
                                (bus.fwd_idx[gi*REG_AW +: REG_AW] == bus.rs_a);
         assign w_match_b[gi] = bus.fwd_valid[gi] &&
                                (bus.fwd_idx[gi*REG_AW +: REG_AW] == bus.rs_b);
      end
   endgenerate

   // Priority bypass: scanning oldest to youngest lets channel 0 overwrite last,
   // so the youngest matching result wins even if it is still pending.
   always_comb begin
      w_ra     = bus.rf_a;
      w_rb     = bus.rf_b;
      w_hit_a  = 1'b0;
      w_hit_b  = 1'b0;
      w_pend_a = 1'b0;
      w_pend_b = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (w_match_a[i]) begin
            w_ra     = bus.fwd_data[i*DATA_W +: DATA_W];
            w_hit_a  = 1'b1;
            w_pend_a = bus.fwd_pend[i];
         end
         if (w_match_b[i]) begin
            w_rb     = bus.fwd_data[i*DATA_W +: DATA_W];
            w_hit_b  = 1'b1;
            w_pend_b = bus.fwd_pend[i];
         end
      end
   end

   assign w_imm_s_sext = {{(DATA_W-IMM_S_W){bus.imm_s[IMM_S_W-1]}}, bus.imm_s};
   assign w_imm_s_zext = {{(DATA_W-IMM_S_W){1'b0}}, bus.imm_s};
   assign w_imm_s_hi   = {bus.imm_s, {(DATA_W-IMM_S_W){1'b0}}};
   // Sign-extended long immediate pre-scaled by two (branch/jump offset form).
   assign w_imm_l_shl  = {{(DATA_W-IMM_L_W-1){bus.imm_l[IMM_L_W-1]}}, bus.imm_l, 1'b0};
   assign w_ra_lo_zext = {{(DATA_W-c_HALF_W){1'b0}}, w_ra[c_HALF_W-1:0]};

   // Operand A source select.
   always_comb begin
      w_op_a = '0;
      case (bus.a_sel)
         2'd0:    w_op_a = w_ra;
         2'd1:    w_op_a = '0;
         2'd2:    w_op_a = w_imm_l_shl;
         2'd3:    w_op_a = w_ra_lo_zext;
         default: w_op_a = '0;
      endcase
   end

   // Operand B source select; codes 5-7 are reserved and yield zero.
   always_comb begin
      w_op_b = '0;
      case (bus.b_sel)
         3'd0:    w_op_b = w_imm_s_sext;
         3'd1:    w_op_b = w_rb;
         3'd2:    w_op_b = bus.pc;
         3'd3:    w_op_b = w_imm_s_hi;
         3'd4:    w_op_b = w_imm_s_zext;
         default: w_op_b = '0;
      endcase
   end

   // Only operands that actually read a register may forward or stall decode.
   assign w_use_a     = (bus.a_sel == 2'd0) || (bus.a_sel == 2'd3);
   assign w_use_b     = (bus.b_sel == 3'd1);
   assign w_fwd_hit_a = w_use_a && w_hit_a;
   assign w_fwd_hit_b = w_use_b && w_hit_b;
   assign w_hazard    = bus.in_valid &&
                        ((w_fwd_hit_a && w_pend_a) || (w_fwd_hit_b && w_pend_b));
   assign w_load      = bus.in_valid && !w_hazard;

   // Output register: flush beats stall; bubbles are always registered clean.
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_valid     <= 1'b0;
         r_fwd_hit_a <= 1'b0;
         r_fwd_hit_b <= 1'b0;
      end else if (!bus.stall) begin
         r_valid     <= w_load;
         r_op_a      <= w_load ? w_op_a : '0;
         r_op_b      <= w_load ? w_op_b : '0;
         r_fwd_hit_a <= w_load && w_fwd_hit_a;
         r_fwd_hit_b <= w_load && w_fwd_hit_b;
      end
   end

   assign bus.op_a      = r_op_a;
   assign bus.op_b      = r_op_b;
   assign bus.out_valid = r_valid;
   assign bus.fwd_hit_a = r_fwd_hit_a;
   assign bus.fwd_hit_b = r_fwd_hit_b;
   assign bus.hazard    = w_hazard;

endmodule
`default_nettype wire
